// File: rtl/riscv_pkg.sv
// +----------------------------------------------------------------------------+
// | riscv_pkg: RV32I opcodes, encoder format codes, NOP word, encoder FSM states |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package riscv_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] OP     = 7'b0110011;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } enc_state_e;

endpackage

`default_nettype wire

// File: rtl/instr_field_pack.sv
// +----------------------------------------------------------------------------+
// | instr_field_pack: combinational RV32I field packer (R/I/S/B/U/J)           |
// | Optional macro IMM_RANGE_CHECK_EN enables immediate representability check |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module instr_field_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        illegal,
  output logic        range_err
);

  always_comb begin
    instr   = NOP_INSTR;
    illegal = 1'b0;
    case (fmt)
      FMT_R: instr = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: instr = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U: instr = {imm[31:12], rd, opcode};
      FMT_J: instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: illegal = 1'b1;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // Immediate must survive the truncation done by the packing above.
  always_comb begin
    range_err = 1'b0;
    case (fmt)
      FMT_I, FMT_S: range_err = (imm != {{20{imm[11]}}, imm[11:0]});
      FMT_B:        range_err = (imm != {{19{imm[12]}}, imm[12:0]}) || imm[0];
      FMT_J:        range_err = (imm != {{11{imm[20]}}, imm[20:0]}) || imm[0];
      FMT_U:        range_err = (imm[11:0] != 12'd0);
      default:      range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// +----------------------------------------------------------------------------+
// | instr_encoder: streaming RV32I encoder with addressed, registered output   |
// | Optional macro IMM_RANGE_CHECK_EN (immediate range errors raise err)       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module instr_encoder
  import riscv_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] c_base_addr = ADDR_W'(BASE_ADDR);

  enc_state_e        r_state;
  enc_state_e        w_next_state;
  logic              w_take_ok;
  logic              w_accept;
  logic              w_out_hs;
  logic              w_restart;
  logic              w_illegal;
  logic              w_range_err;
  logic [31:0]       w_instr;
  logic [ADDR_W-1:0] r_addr_cnt;

  instr_field_pack u_pack (
    .fmt       (in_fmt),
    .opcode    (in_opcode),
    .rd        (in_rd),
    .rs1       (in_rs1),
    .rs2       (in_rs2),
    .funct3    (in_funct3),
    .funct7    (in_funct7),
    .imm       (in_imm),
    .instr     (w_instr),
    .illegal   (w_illegal),
    .range_err (w_range_err)
  );

  assign w_take_ok = !out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_out_hs  = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_restart    = 1'b0;
    in_ready     = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = ST_RUN;
          w_restart    = 1'b1;
        end
      end
      ST_RUN: begin
        in_ready = w_take_ok;
        if (in_valid && w_take_ok && in_last) w_next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_out_hs && out_last) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          w_next_state = ST_RUN;
          w_restart    = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // The counter holds the address of the next accepted word; every accepted
  // word is eventually handed off, so this tracks the handshake count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_instr  <= NOP_INSTR;
      out_addr   <= c_base_addr;
      r_addr_cnt <= c_base_addr;
      err        <= 1'b0;
    end else begin
      if (w_restart) begin
        r_addr_cnt <= c_base_addr;
        err        <= 1'b0;
      end
      if (w_accept) begin
        out_valid  <= 1'b1;
        out_instr  <= w_instr;
        out_addr   <= r_addr_cnt;
        out_last   <= in_last;
        r_addr_cnt <= r_addr_cnt + 1'b1;
        if (w_illegal || w_range_err) err <= 1'b1;
      end else if (w_out_hs) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
